// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 constants: register addresses, field positions, exception codes
// and the EXL state encoding.
package cp0_exc_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ADDRW = 5;
    localparam int unsigned EXCW  = 5;
    localparam int unsigned INTW  = 6;

    // Register select values
    localparam logic [ADDRW-1:0] ADDR_SR    = 5'd12;
    localparam logic [ADDRW-1:0] ADDR_CAUSE = 5'd13;
    localparam logic [ADDRW-1:0] ADDR_EPC   = 5'd14;

    // SR fields
    localparam int unsigned SR_IM_MSB  = 15;
    localparam int unsigned SR_IM_LSB  = 10;
    localparam int unsigned SR_EXL_BIT = 1;
    localparam int unsigned SR_IE_BIT  = 0;

    // Cause fields
    localparam int unsigned CAUSE_BD_BIT  = 31;
    localparam int unsigned CAUSE_IP_MSB  = 15;
    localparam int unsigned CAUSE_IP_LSB  = 10;
    localparam int unsigned CAUSE_EXC_MSB = 6;
    localparam int unsigned CAUSE_EXC_LSB = 2;

    // EPC is word aligned
    localparam logic [XLEN-1:0] EPC_MASK = 32'hFFFF_FFFC;

    // Exception codes
    localparam logic [EXCW-1:0] EXC_INT     = 5'd0;
    localparam logic [EXCW-1:0] EXC_SYSCALL = 5'd8;
    localparam logic [EXCW-1:0] EXC_BREAK   = 5'd9;
    localparam logic [EXCW-1:0] EXC_TRAP    = 5'd13;

    localparam logic [XLEN-1:0] DEF_HANDLER_PC = 32'h0000_4180;

    // SR.EXL viewed as a two-state machine
    typedef enum logic {
        ST_NORMAL     = 1'b0,
        ST_IN_HANDLER = 1'b1
    } exl_state_e;

endpackage

// File: rtl/cp0_req_arb.sv
// Exception/interrupt request arbiter (combinational).
// Ports: hw_int/sr_im/sr_ie/sr_exl/exc_code in; int_req, exc_req and the
// selected ExcCode out. Interrupts take priority over instruction exceptions.
module cp0_req_arb
    import cp0_exc_unit_pkg::*;
(
    input  logic [INTW-1:0] hw_int,
    input  logic [INTW-1:0] sr_im,
    input  logic            sr_ie,
    input  logic            sr_exl,
    input  logic [EXCW-1:0] exc_code,
    output logic            int_req,
    output logic            exc_req,
    output logic [EXCW-1:0] code
);

    always_comb begin
        int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
        exc_req = (exc_code != EXC_INT) & ~sr_exl;
        code    = int_req ? EXC_INT : exc_code;
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception consumer: decides whether to take an exception at M, keeps
// SR/Cause/EPC, and drives the flush/redirect request and handler/return PCs.
// Ports: clk, rst_n; M-stage pc_m/bd_m/exc_code_m/eret_m; hw_int lines;
// mtc0 we/cp0_addr/cp0_wdata; mfc0 cp0_rdata; req, epc_out, handler_pc.
module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [31:0] SR_RESET   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pc_m,
    input  logic             bd_m,
    input  logic [EXCW-1:0]  exc_code_m,
    input  logic [INTW-1:0]  hw_int,
    input  logic             eret_m,
    input  logic             we,
    input  logic [ADDRW-1:0] cp0_addr,
    input  logic [XLEN-1:0]  cp0_wdata,
    output logic [XLEN-1:0]  cp0_rdata,
    output logic             req,
    output logic [XLEN-1:0]  epc_out,
    output logic [XLEN-1:0]  handler_pc
);

    exl_state_e      state, state_n;
    logic [INTW-1:0] sr_im, sr_im_n;
    logic            sr_ie, sr_ie_n;
    logic            sr_exl;
    logic            cause_bd, cause_bd_n;
    logic [INTW-1:0] cause_ip;
    logic [EXCW-1:0] cause_exc, cause_exc_n;
    logic [XLEN-1:0] epc, epc_n;

    logic            int_req, exc_req;
    logic [EXCW-1:0] sel_code;
    logic            wr_sr, wr_epc;

    assign sr_exl     = (state == ST_IN_HANDLER);
    assign handler_pc = HANDLER_PC;

    cp0_req_arb u_arb (
        .hw_int   (hw_int),
        .sr_im    (sr_im),
        .sr_ie    (sr_ie),
        .sr_exl   (sr_exl),
        .exc_code (exc_code_m),
        .int_req  (int_req),
        .exc_req  (exc_req),
        .code     (sel_code)
    );

    assign req = int_req | exc_req;

    // Next-state: exception entry overrides any same-cycle mtc0 or eret
    always_comb begin
        state_n     = state;
        sr_im_n     = sr_im;
        sr_ie_n     = sr_ie;
        cause_bd_n  = cause_bd;
        cause_exc_n = cause_exc;
        epc_n       = epc;
        wr_sr       = we && (cp0_addr == ADDR_SR)  && !req;
        wr_epc      = we && (cp0_addr == ADDR_EPC) && !req;
        if (req) begin
            state_n     = ST_IN_HANDLER;
            cause_bd_n  = bd_m;
            cause_exc_n = sel_code;
            epc_n       = (bd_m ? (pc_m - 32'd4) : pc_m) & EPC_MASK;
        end else begin
            if (wr_sr) begin
                sr_im_n = cp0_wdata[SR_IM_MSB:SR_IM_LSB];
                sr_ie_n = cp0_wdata[SR_IE_BIT];
                state_n = exl_state_e'(cp0_wdata[SR_EXL_BIT]);
            end
            if (wr_epc) begin
                epc_n = cp0_wdata & EPC_MASK;
            end
            // eret after the SR write so a combined exit always clears EXL
            if (eret_m) begin
                state_n = ST_NORMAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= exl_state_e'(SR_RESET[SR_EXL_BIT]);
            sr_im     <= SR_RESET[SR_IM_MSB:SR_IM_LSB];
            sr_ie     <= SR_RESET[SR_IE_BIT];
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            state     <= state_n;
            sr_im     <= sr_im_n;
            sr_ie     <= sr_ie_n;
            cause_bd  <= cause_bd_n;
            cause_ip  <= hw_int;
            cause_exc <= cause_exc_n;
            epc       <= epc_n;
        end
    end

    // mfc0 read mux; unmapped addresses and reserved bits read 0
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_SR: begin
                cp0_rdata[SR_IM_MSB:SR_IM_LSB] = sr_im;
                cp0_rdata[SR_EXL_BIT]          = sr_exl;
                cp0_rdata[SR_IE_BIT]           = sr_ie;
            end
            ADDR_CAUSE: begin
                cp0_rdata[CAUSE_BD_BIT]                = cause_bd;
                cp0_rdata[CAUSE_IP_MSB:CAUSE_IP_LSB]   = cause_ip;
                cp0_rdata[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = cause_exc;
            end
            ADDR_EPC: cp0_rdata = epc;
            default:  cp0_rdata = '0;
        endcase
    end

    // Return address forwards an mtc0 EPC issued alongside eret
    always_comb begin
        if (we && (cp0_addr == ADDR_EPC) && eret_m && !req) begin
            epc_out = cp0_wdata & EPC_MASK;
        end else begin
            epc_out = epc;
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
module tb_cp0_exc_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic [5:0]  hw_int;
    logic        eret_m;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    int errors = 0;
    int checks = 0;

    cp0_exc_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_m       (pc_m),
        .bd_m       (bd_m),
        .exc_code_m (exc_code_m),
        .hw_int     (hw_int),
        .eret_m     (eret_m),
        .we         (we),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .cp0_rdata  (cp0_rdata),
        .req        (req),
        .epc_out    (epc_out),
        .handler_pc (handler_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        eret;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        exp_req;
        logic [31:0] exp_epc_out;
        logic [31:0] exp_sr;
        logic [31:0] exp_cause;
        logic [31:0] exp_epc;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] sr;
        logic [31:0] cause;
        logic [31:0] epc;
    } exp_t;

    localparam int NV = 15;
    vec_t vecs [NV];
    exp_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic idle_inputs();
        pc_m = '0; bd_m = 1'b0; exc_code_m = '0; eret_m = 1'b0;
        we = 1'b0; cp0_addr = '0; cp0_wdata = '0;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] sr,
                              input logic [31:0] cause, input logic [31:0] epc);
        logic [31:0] d;
        rd(5'd12, d); chk({tag, " SR"}, d, sr);
        rd(5'd13, d); chk({tag, " Cause"}, d, cause);
        rd(5'd14, d); chk({tag, " EPC"}, d, epc);
    endtask

    initial begin
        exp_t e;
        logic [31:0] d;

        //           pc            bd    exc    hw     eret  we    addr   wdata          req   epc_out        SR             Cause          EPC
        vecs[0]  = '{32'h3000,     1'b0, 5'd9,  6'h00, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 32'h0,         32'h0000_0002, 32'h0000_0024, 32'h0000_3000};
        vecs[1]  = '{32'h3100,     1'b0, 5'd8,  6'h3F, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h3000,      32'h0000_0002, 32'h0000_FC24, 32'h0000_3000};
        vecs[2]  = '{32'h0,        1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 32'h3000,      32'h0000_0000, 32'h0000_0024, 32'h0000_3000};
        vecs[3]  = '{32'h3008,     1'b1, 5'd13, 6'h00, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 32'h3000,      32'h0000_0002, 32'h8000_0034, 32'h0000_3004};
        vecs[4]  = '{32'h0,        1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 32'h3004,      32'h0000_0000, 32'h8000_0034, 32'h0000_3004};
        vecs[5]  = '{32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b1, 5'd12, 32'h0000_0401, 1'b0, 32'h3004,      32'h0000_0401, 32'h8000_0034, 32'h0000_3004};
        vecs[6]  = '{32'h5000,     1'b0, 5'd8,  6'h01, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 32'h3004,      32'h0000_0403, 32'h0000_0400, 32'h0000_5000};
        vecs[7]  = '{32'h5100,     1'b0, 5'd8,  6'h3F, 1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h5000,      32'h0000_0403, 32'h0000_FC00, 32'h0000_5000};
        vecs[8]  = '{32'h0,        1'b0, 5'd0,  6'h00, 1'b1, 1'b1, 5'd14, 32'h0000_4003, 1'b0, 32'h4000,      32'h0000_0401, 32'h0000_0000, 32'h0000_4000};
        vecs[9]  = '{32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 32'h4000,      32'h0000_0401, 32'h0000_0000, 32'h0000_4000};
        vecs[10] = '{32'h0,        1'b1, 5'd9,  6'h00, 1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF, 1'b1, 32'h4000,      32'h0000_0403, 32'h8000_0024, 32'hFFFF_FFFC};
        vecs[11] = '{32'h0,        1'b0, 5'd0,  6'h00, 1'b1, 1'b1, 5'd12, 32'h0000_0001, 1'b0, 32'hFFFF_FFFC, 32'h0000_0001, 32'h8000_0024, 32'hFFFF_FFFC};
        vecs[12] = '{32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b1, 5'd12, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFC, 32'h0000_FC02, 32'h8000_0024, 32'hFFFF_FFFC};
        vecs[13] = '{32'h0,        1'b0, 5'd0,  6'h00, 1'b0, 1'b1, 5'd12, 32'h0000_FC01, 1'b0, 32'hFFFF_FFFC, 32'h0000_FC01, 32'h8000_0024, 32'hFFFF_FFFC};
        vecs[14] = '{32'h0000_0010,1'b1, 5'd0,  6'h20, 1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0000_FC03, 32'h8000_8000, 32'h0000_000C};

        idle_inputs();
        hw_int = '0;
        rst_n  = 1'b0;
        #12;
        chk("reset req", {31'b0, req}, 32'h0);
        chk("reset epc_out", epc_out, 32'h0);
        chk("handler_pc", handler_pc, 32'h0000_4180);
        check_regs("reset", 32'h0, 32'h0, 32'h0);
        rd(5'd0, d);  chk("unmapped 0", d, 32'h0);
        rd(5'd15, d); chk("unmapped 15", d, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            pc_m = vecs[i].pc; bd_m = vecs[i].bd; exc_code_m = vecs[i].exc;
            hw_int = vecs[i].hw; eret_m = vecs[i].eret; we = vecs[i].we;
            cp0_addr = vecs[i].addr; cp0_wdata = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d req", i), {31'b0, req}, {31'b0, vecs[i].exp_req});
            chk($sformatf("v%0d epc_out", i), epc_out, vecs[i].exp_epc_out);
            sb.push_back('{i, vecs[i].exp_sr, vecs[i].exp_cause, vecs[i].exp_epc});
            @(posedge clk);
            #1;
            idle_inputs();
            e = sb.pop_front();
            check_regs($sformatf("v%0d", e.idx), e.sr, e.cause, e.epc);
        end

        // Asynchronous reset mid-cycle while in the handler
        @(negedge clk);
        idle_inputs();
        hw_int = 6'h3F;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst req", {31'b0, req}, 32'h0);
        chk("midrst epc_out", epc_out, 32'h0);
        check_regs("midrst", 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst req", {31'b0, req}, 32'h0);
        check_regs("postrst", 32'h0, 32'h0000_FC00, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
